rank_change_logger: RTL

- Sits directly downstream of the second-largest tracker and watches its registered second-largest output every cycle.
- Each time that value changes, it logs an event {timestamp, new value} into a small FIFO.
- The FIFO drains through a valid/ready interface toward the debug/readout path.
- Provides sticky overflow indication and a saturating drop counter so lost events are never silent.

---
 rtl/rank_log_pkg.sv | 26 ++
 rtl/rank_evt_fifo.sv | 74 +++++++
 rtl/rank_change_logger.sv | 113 +++++++++++
 3 files changed

// File: rtl/rank_log_pkg.sv
// -----------------------------------------------------------------------------
// rank_log_pkg
// Shared types and helpers for the rank change logger.
//   RANK_*          : default widths/depth used by the logger
//   RANK_PTR_W      : FIFO pointer width for the default depth (index + wrap bit)
//   rank_evt_t      : one logged event {timestamp, value} at default widths
//   ptr_width()     : pointer width for an arbitrary power-of-two depth
// -----------------------------------------------------------------------------
package rank_log_pkg;

  localparam int RANK_DATA_W = 32;
  localparam int RANK_TS_W   = 16;
  localparam int RANK_DEPTH  = 8;
  localparam int RANK_PTR_W  = $clog2(RANK_DEPTH) + 1;

  typedef struct packed {
    logic [RANK_TS_W-1:0]   ts;
    logic [RANK_DATA_W-1:0] value;
  } rank_evt_t;

  // One extra bit above the index distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rank_evt_fifo.sv
// -----------------------------------------------------------------------------
// rank_evt_fifo
// Generic show-ahead synchronous FIFO.
//   clk, reset (async, active-high), clr (sync, highest priority)
//   push/wdata : write request; ignored when full unless a pop frees a slot
//   pop        : read request; ignored when empty
//   rdata      : head entry, combinational from storage; zero when empty
//   full/empty : occupancy flags
//   level      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module rank_evt_fifo
  import rank_log_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level = wptr_q - rptr_q;

  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the head slot, so a push into a full FIFO is accepted.
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rank_change_logger.sv
// -----------------------------------------------------------------------------
// rank_change_logger
// Watches the tracker's second-largest output and logs {timestamp, value} into
// a FIFO each time it changes; the FIFO drains over a valid/ready port.
//   clk, reset     : clock, async active-high reset
//   din            : monitored value, sampled every cycle
//   clr            : sync clear (FIFO, previous value, timestamp, drop stats)
//   dout_valid     : head entry available
//   dout_ready     : consumer accepts head entry
//   dout_value     : head entry value (0 when empty)
//   dout_ts        : head entry timestamp (0 when empty)
//   level          : FIFO occupancy
//   overflow       : sticky, at least one event dropped
//   drop_cnt       : saturating count of dropped events
// -----------------------------------------------------------------------------
module rank_change_logger
  import rank_log_pkg::*;
#(
  parameter int DATA_WIDTH = RANK_DATA_W,
  parameter int TS_WIDTH   = RANK_TS_W,
  parameter int DEPTH      = RANK_DEPTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   clr,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [DATA_WIDTH-1:0]  dout_value,
  output logic [TS_WIDTH-1:0]    dout_ts,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   drop_cnt
);

  typedef struct packed {
    logic [TS_WIDTH-1:0]   ts;
    logic [DATA_WIDTH-1:0] value;
  } evt_t;

  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic change, pop, drop;
  logic fifo_full, fifo_empty;
  evt_t wevt, revt;

  assign change = (din != prev_q);
  assign pop    = dout_valid && dout_ready;
  assign drop   = change && fifo_full && !pop;
  assign wevt   = '{ts: ts_q, value: din};

  always_comb begin
    prev_d     = prev_q;
    ts_d       = ts_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      prev_d     = '0;
      ts_d       = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      prev_d = din;
      ts_d   = ts_q + 1'b1;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      prev_q     <= prev_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // The FIFO applies clr with priority, discarding any same-cycle push or pop.
  rank_evt_fifo #(
    .WIDTH (TS_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (change),
    .wdata (wevt),
    .pop   (pop),
    .rdata (revt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign dout_valid = !fifo_empty;
  assign dout_value = revt.value;
  assign dout_ts    = revt.ts;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
